fpadd_param: RTL



---
 rtl/fpadd_param_if.sv | 11 +
 rtl/fpadd_param.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fpadd_param_if.sv
// fpadd_param_if: request/result bundle between a requester (master) and fpadd_param (slave).
interface fpadd_param_if #(
   parameter int EXP_W = 3,
   parameter int MAN_W = 4
);
   localparam int W = 1 + EXP_W + MAN_W;
   logic         start, op, busy, done, ovf, unf;
   logic [W-1:0] a, b, s;
   modport master (output start, op, a, b, input s, busy, done, ovf, unf);
   modport slave  (input start, op, a, b, output s, busy, done, ovf, unf);
endinterface

// File: rtl/fpadd_param.sv
// fpadd_param: parametrised multi-cycle FP add/sub (swap, iterative align, add, iterative normalise, pack).
// Define ROUND_NEAREST_EN for round-to-nearest-even at pack time; otherwise results truncate.
module fpadd_param #(
   parameter int EXP_W = 3,
   parameter int MAN_W = 4
) (
   input  logic         clk,
   input  logic         clr,
   fpadd_param_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 5;
   localparam int EW = EXP_W + $clog2(MAN_W + 6) + 2;
   localparam logic signed [EW-1:0] CAP  = EW'(MAN_W + 3);
   localparam logic signed [EW-1:0] MAXE = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] ONE  = EW'(1);
   typedef enum logic [2:0] {IDLE, LOAD, ALIGN, ADD, NORM, DONE} state_t;
   state_t               r_state, w_next;
   logic [W-1:0]         r_a, r_b, r_s, w_x, w_y, w_s;
   logic                 r_op, r_sign, r_sub, r_ovf, r_unf, w_bs, w_swap, w_nz, w_fin, w_ovf, w_unf;
   logic [MW-1:0]        r_xm, r_ym, w_xm0, w_ym0;
   logic signed [EW-1:0] r_xe, r_ye, w_xe0, w_ye0, w_d, w_pe;
   logic [MAN_W-1:0]     w_pf;

   // {exp,frac} compares as one unsigned magnitude; b carries the effective sign
   assign w_bs   = r_b[W-1] ^ r_op;
   assign w_swap = r_b[W-2:0] > r_a[W-2:0];
   assign w_x    = w_swap ? {w_bs, r_b[W-2:0]} : r_a;
   assign w_y    = w_swap ? r_a : {w_bs, r_b[W-2:0]};
   assign w_xe0  = EW'(w_x[W-2:MAN_W]);
   assign w_ye0  = EW'(w_y[W-2:MAN_W]);
   assign w_xm0  = (w_xe0 == '0) ? '0 : {2'b01, w_x[MAN_W-1:0], 3'b000};
   assign w_ym0  = (w_ye0 == '0) ? '0 : {2'b01, w_y[MAN_W-1:0], 3'b000};
   assign w_d    = w_xe0 - w_ye0;
   assign w_nz   = |r_xm;
   assign w_fin  = !w_nz || (!r_xm[MW-1] && r_xm[MW-2]);

`ifdef ROUND_NEAREST_EN
   logic [MAN_W+1:0] w_q;
   assign w_q  = r_xm[MW-1:3] + (MAN_W+2)'(r_xm[2] & (r_xm[3] | r_xm[1] | r_xm[0]));
   assign w_pf = w_q[MAN_W+1] ? w_q[MAN_W:1] : w_q[MAN_W-1:0];
   assign w_pe = r_xe + EW'(w_q[MAN_W+1]);
`else
   assign w_pf = r_xm[MW-3:3];
   assign w_pe = r_xe;
`endif

   assign w_ovf = w_nz && (w_pe > MAXE);
   assign w_unf = w_nz && (w_pe[EW-1] || w_pe == '0);
   assign w_s   = !w_nz ? '0 : w_ovf ? {r_sign, {(W-1){1'b1}}} :
                  w_unf ? {r_sign, {(W-1){1'b0}}} : {r_sign, w_pe[EXP_W-1:0], w_pf};
   assign bus.s   = r_s;
   assign bus.ovf = r_ovf;
   assign bus.unf = r_unf;

   always_ff @(posedge clk) begin
      if (clr) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = bus.start ? LOAD : IDLE;
         LOAD:    w_next = ALIGN;
         ALIGN:   w_next = (r_xe == r_ye) ? ADD : ALIGN;
         ADD:     w_next = NORM;
         NORM:    w_next = w_fin ? DONE : NORM;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = r_state != IDLE;
      bus.done = r_state == DONE;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_s   <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               r_a  <= bus.a;
               r_b  <= bus.b;
               r_op <= bus.op;
            end
            LOAD: begin
               r_sign <= w_x[W-1];
               r_sub  <= w_x[W-1] ^ w_y[W-1];
               r_xm   <= w_xm0;
               r_xe   <= w_xe0;
               r_ym   <= (w_d > CAP) ? {{(MW-1){1'b0}}, |w_ym0} : w_ym0;
               r_ye   <= (w_d > CAP) ? w_xe0 - CAP : w_ye0;
            end
            ALIGN: if (r_xe != r_ye) begin
               r_ym <= {1'b0, r_ym[MW-1:2], |r_ym[1:0]};
               r_ye <= r_ye + ONE;
            end
            ADD: r_xm <= r_sub ? r_xm - r_ym : r_xm + r_ym;
            NORM: begin
               if (w_fin) begin
                  r_s   <= w_s;
                  r_ovf <= w_ovf;
                  r_unf <= w_unf;
               end else if (r_xm[MW-1]) begin
                  r_xm <= {1'b0, r_xm[MW-1:2], |r_xm[1:0]};
                  r_xe <= r_xe + ONE;
               end else begin
                  r_xm <= r_xm << 1;
                  r_xe <= r_xe - ONE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
